// File: rtl/store_buffer.sv
// In-order store buffer between the MEM stage and the single-port data memory.
// Drains stores whenever no load owns the port and forwards the youngest matching data to loads.
module store_buffer #(
    parameter int DSIZE = 16,
    parameter int ASIZE = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     st_valid,
    input  logic [ASIZE-1:0]         st_addr,
    input  logic [DSIZE-1:0]         st_data,
    output logic                     st_ready,
    input  logic                     ld_valid,
    input  logic [ASIZE-1:0]         ld_addr,
    output logic                     ld_hit,
    output logic [DSIZE-1:0]         ld_fwd_data,
    output logic                     mem_wen,
    output logic [ASIZE-1:0]         mem_addr,
    output logic [DSIZE-1:0]         mem_wdata,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [ASIZE-1:0] addr_q [DEPTH];
    logic [ASIZE-1:0] addr_d [DEPTH];
    logic [DSIZE-1:0] data_q [DEPTH];
    logic [DSIZE-1:0] data_d [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;

    logic push;
    logic pop;
    logic [PW-1:0] idx;

    assign st_ready  = (count_q < DEPTH_C);
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign push      = st_valid && st_ready;
    assign mem_wen   = !empty && !ld_valid;
    assign pop       = mem_wen;
    assign mem_addr  = mem_wen ? addr_q[head_q] : '0;
    assign mem_wdata = mem_wen ? data_q[head_q] : '0;

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        ld_hit      = 1'b0;
        ld_fwd_data = '0;
        idx         = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (valid_q[idx] && (addr_q[idx] == ld_addr)) begin
                ld_hit      = 1'b1;
                ld_fwd_data = data_q[idx];
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PW'(1);
        end
        if (push) begin
            valid_d[tail_q] = 1'b1;
            addr_d[tail_q]  = st_addr;
            data_d[tail_q]  = st_data;
            tail_d          = tail_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed, table-driven bench for store_buffer with a memory write log model.
module tb_store_buffer;

    logic        clk;
    logic        rst;
    logic        st_valid;
    logic [15:0] st_addr;
    logic [15:0] st_data;
    logic        st_ready;
    logic        ld_valid;
    logic [15:0] ld_addr;
    logic        ld_hit;
    logic [15:0] ld_fwd_data;
    logic        mem_wen;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        empty;
    logic [2:0]  count;

    int checks   = 0;
    int failures = 0;

    store_buffer #(.DSIZE(16), .ASIZE(16), .DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .st_valid    (st_valid),
        .st_addr     (st_addr),
        .st_data     (st_data),
        .st_ready    (st_ready),
        .ld_valid    (ld_valid),
        .ld_addr     (ld_addr),
        .ld_hit      (ld_hit),
        .ld_fwd_data (ld_fwd_data),
        .mem_wen     (mem_wen),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .empty       (empty),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mem [logic [15:0]];
    logic [15:0] wlog_a [$];
    logic [15:0] wlog_d [$];

    always @(posedge clk) begin
        if (mem_wen === 1'b1) begin
            mem[mem_addr] = mem_wdata;
            wlog_a.push_back(mem_addr);
            wlog_d.push_back(mem_wdata);
        end
    end

    typedef struct {
        logic        rst;
        logic        stv;
        logic [15:0] sta;
        logic [15:0] std;
        logic        ldv;
        logic [15:0] lda;
        logic        rdy;
        logic        emp;
        logic [2:0]  cnt;
        logic        wen;
        logic [15:0] ma;
        logic [15:0] md;
        logic        hit;
        logic [15:0] fwd;
    } vec_t;

    vec_t vecs [$];

    task automatic add(input logic r, input logic sv, input logic [15:0] sa, input logic [15:0] sd,
                       input logic lv, input logic [15:0] la,
                       input logic rdy, input logic emp, input logic [2:0] cnt,
                       input logic wen, input logic [15:0] ma, input logic [15:0] md,
                       input logic hit, input logic [15:0] fwd);
        vec_t v;
        v = '{rst:r, stv:sv, sta:sa, std:sd, ldv:lv, lda:la, rdy:rdy, emp:emp, cnt:cnt,
              wen:wen, ma:ma, md:md, hit:hit, fwd:fwd};
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic sv, input logic [15:0] sa, input logic [15:0] sd,
                         input logic lv, input logic [15:0] la);
        rst      = r;
        st_valid = sv;
        st_addr  = sa;
        st_data  = sd;
        ld_valid = lv;
        ld_addr  = la;
    endtask

    logic [15:0] exp_wa [14] = '{16'h0010, 16'h0100, 16'h0101, 16'h0102, 16'h0103,
                                 16'h0020, 16'h0020, 16'h0030, 16'h0040, 16'h0041,
                                 16'h0042, 16'h0043, 16'h0044, 16'h0050};
    logic [15:0] exp_wd [14] = '{16'hBEEF, 16'hA001, 16'hA002, 16'hA003, 16'hA004,
                                 16'h1111, 16'h2222, 16'hC000, 16'hC001, 16'hC002,
                                 16'hC003, 16'hC004, 16'hC005, 16'hD001};

    initial begin
        //   rst sv addr     data     lv lda      | rdy emp cnt wen maddr    mdata    hit fwd
        add(0, 0, 16'h0000, 16'h0000, 0, 16'h0000,  1, 1, 3'd0, 0, 16'h0000, 16'h0000, 0, 16'h0000);
        add(0, 1, 16'h0010, 16'hBEEF, 0, 16'h0000,  1, 1, 3'd0, 0, 16'h0000, 16'h0000, 0, 16'h0000);
        add(0, 0, 16'h0000, 16'h0000, 0, 16'h0010,  1, 0, 3'd1, 1, 16'h0010, 16'hBEEF, 1, 16'hBEEF);
        add(0, 0, 16'h0000, 16'h0000, 0, 16'h0010,  1, 1, 3'd0, 0, 16'h0000, 16'h0000, 0, 16'h0000);
        add(0, 1, 16'h0100, 16'hA001, 1, 16'h0100,  1, 1, 3'd0, 0, 16'h0000, 16'h0000, 0, 16'h0000);
        add(0, 1, 16'h0101, 16'hA002, 1, 16'h0100,  1, 0, 3'd1, 0, 16'h0000, 16'h0000, 1, 16'hA001);
        add(0, 1, 16'h0102, 16'hA003, 1, 16'h0103,  1, 0, 3'd2, 0, 16'h0000, 16'h0000, 0, 16'h0000);
        add(0, 1, 16'h0103, 16'hA004, 1, 16'h0102,  1, 0, 3'd3, 0, 16'h0000, 16'h0000, 1, 16'hA003);
        add(0, 1, 16'h0104, 16'hA005, 1, 16'h0104,  0, 0, 3'd4, 0, 16'h0000, 16'h0000, 0, 16'h0000);
        add(0, 0, 16'h0000, 16'h0000, 1, 16'h0103,  0, 0, 3'd4, 0, 16'h0000, 16'h0000, 1, 16'hA004);
        add(0, 0, 16'h0000, 16'h0000, 0, 16'h0000,  0, 0, 3'd4, 1, 16'h0100, 16'hA001, 0, 16'h0000);
        add(0, 0, 16'h0000, 16'h0000, 0, 16'h0000,  1, 0, 3'd3, 1, 16'h0101, 16'hA002, 0, 16'h0000);
        add(0, 0, 16'h0000, 16'h0000, 0, 16'h0000,  1, 0, 3'd2, 1, 16'h0102, 16'hA003, 0, 16'h0000);
        add(0, 0, 16'h0000, 16'h0000, 0, 16'h0000,  1, 0, 3'd1, 1, 16'h0103, 16'hA004, 0, 16'h0000);
        add(0, 0, 16'h0000, 16'h0000, 0, 16'h0000,  1, 1, 3'd0, 0, 16'h0000, 16'h0000, 0, 16'h0000);
        add(0, 1, 16'h0020, 16'h1111, 1, 16'h0020,  1, 1, 3'd0, 0, 16'h0000, 16'h0000, 0, 16'h0000);
        add(0, 1, 16'h0020, 16'h2222, 1, 16'h0020,  1, 0, 3'd1, 0, 16'h0000, 16'h0000, 1, 16'h1111);
        add(0, 0, 16'h0000, 16'h0000, 1, 16'h0020,  1, 0, 3'd2, 0, 16'h0000, 16'h0000, 1, 16'h2222);
        add(0, 0, 16'h0000, 16'h0000, 1, 16'h0021,  1, 0, 3'd2, 0, 16'h0000, 16'h0000, 0, 16'h0000);
        add(0, 0, 16'h0000, 16'h0000, 0, 16'h0020,  1, 0, 3'd2, 1, 16'h0020, 16'h1111, 1, 16'h2222);
        add(0, 0, 16'h0000, 16'h0000, 0, 16'h0020,  1, 0, 3'd1, 1, 16'h0020, 16'h2222, 1, 16'h2222);
        add(0, 0, 16'h0000, 16'h0000, 0, 16'h0000,  1, 1, 3'd0, 0, 16'h0000, 16'h0000, 0, 16'h0000);
        add(0, 1, 16'h0030, 16'hC000, 1, 16'h0000,  1, 1, 3'd0, 0, 16'h0000, 16'h0000, 0, 16'h0000);
        add(0, 0, 16'h0000, 16'h0000, 0, 16'h0000,  1, 0, 3'd1, 1, 16'h0030, 16'hC000, 0, 16'h0000);
        add(0, 1, 16'h0040, 16'hC001, 1, 16'h0000,  1, 1, 3'd0, 0, 16'h0000, 16'h0000, 0, 16'h0000);
        add(0, 1, 16'h0041, 16'hC002, 1, 16'h0000,  1, 0, 3'd1, 0, 16'h0000, 16'h0000, 0, 16'h0000);
        add(0, 1, 16'h0042, 16'hC003, 1, 16'h0000,  1, 0, 3'd2, 0, 16'h0000, 16'h0000, 0, 16'h0000);
        add(0, 1, 16'h0043, 16'hC004, 0, 16'h0043,  1, 0, 3'd3, 1, 16'h0040, 16'hC001, 0, 16'h0000);
        add(0, 1, 16'h0044, 16'hC005, 0, 16'h0043,  1, 0, 3'd3, 1, 16'h0041, 16'hC002, 1, 16'hC004);
        add(0, 0, 16'h0000, 16'h0000, 0, 16'h0044,  1, 0, 3'd3, 1, 16'h0042, 16'hC003, 1, 16'hC005);
        add(0, 0, 16'h0000, 16'h0000, 0, 16'h0000,  1, 0, 3'd2, 1, 16'h0043, 16'hC004, 0, 16'h0000);
        add(0, 0, 16'h0000, 16'h0000, 0, 16'h0000,  1, 0, 3'd1, 1, 16'h0044, 16'hC005, 0, 16'h0000);
        add(0, 0, 16'h0000, 16'h0000, 0, 16'h0000,  1, 1, 3'd0, 0, 16'h0000, 16'h0000, 0, 16'h0000);
        add(0, 1, 16'h0050, 16'hD001, 1, 16'h0000,  1, 1, 3'd0, 0, 16'h0000, 16'h0000, 0, 16'h0000);
        add(0, 1, 16'h0051, 16'hD002, 1, 16'h0000,  1, 0, 3'd1, 0, 16'h0000, 16'h0000, 0, 16'h0000);
        add(0, 1, 16'h0052, 16'hD003, 1, 16'h0000,  1, 0, 3'd2, 0, 16'h0000, 16'h0000, 0, 16'h0000);
        add(0, 0, 16'h0000, 16'h0000, 0, 16'h0000,  1, 0, 3'd3, 1, 16'h0050, 16'hD001, 0, 16'h0000);
        add(1, 0, 16'h0000, 16'h0000, 1, 16'h0051,  1, 0, 3'd2, 0, 16'h0000, 16'h0000, 1, 16'hD002);
        add(0, 0, 16'h0000, 16'h0000, 0, 16'h0051,  1, 1, 3'd0, 0, 16'h0000, 16'h0000, 0, 16'h0000);
        add(0, 0, 16'h0000, 16'h0000, 0, 16'h0000,  1, 1, 3'd0, 0, 16'h0000, 16'h0000, 0, 16'h0000);

        drive(1, 0, '0, '0, 0, '0);
        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].stv, vecs[i].sta, vecs[i].std, vecs[i].ldv, vecs[i].lda);
            #1;
            chk($sformatf("v%0d_st_ready", i), 32'(st_ready), 32'(vecs[i].rdy));
            chk($sformatf("v%0d_empty", i), 32'(empty), 32'(vecs[i].emp));
            chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].cnt));
            chk($sformatf("v%0d_mem_wen", i), 32'(mem_wen), 32'(vecs[i].wen));
            chk($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].ma));
            chk($sformatf("v%0d_mem_wdata", i), 32'(mem_wdata), 32'(vecs[i].md));
            chk($sformatf("v%0d_ld_hit", i), 32'(ld_hit), 32'(vecs[i].hit));
            chk($sformatf("v%0d_ld_fwd_data", i), 32'(ld_fwd_data), 32'(vecs[i].fwd));
        end

        // Fill the buffer completely, then reset it while a load holds the port.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(0, 1, 16'h0060 + 16'(i), 16'hE000 + 16'(i), 1, '0);
        end
        @(negedge clk);
        drive(1, 0, '0, '0, 1, 16'h0063);
        #1;
        chk("full_count", 32'(count), 32'd4);
        chk("full_st_ready", 32'(st_ready), 32'd0);
        chk("full_fwd", 32'(ld_fwd_data), 32'hE003);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(0, 0, '0, '0, 0, 16'h0060);
            #1;
            chk($sformatf("rst_full_empty_%0d", i), 32'(empty), 32'd1);
            chk($sformatf("rst_full_wen_%0d", i), 32'(mem_wen), 32'd0);
            chk($sformatf("rst_full_hit_%0d", i), 32'(ld_hit), 32'd0);
        end
        @(negedge clk);

        chk("write_log_len", 32'(wlog_a.size()), 32'd14);
        for (int i = 0; i < 14; i++) begin
            if (i < wlog_a.size()) begin
                chk($sformatf("wlog%0d_addr", i), 32'(wlog_a[i]), 32'(exp_wa[i]));
                chk($sformatf("wlog%0d_data", i), 32'(wlog_d[i]), 32'(exp_wd[i]));
            end
        end
        chk("mem_0010", 32'(mem.exists(16'h0010) ? mem[16'h0010] : 16'h0000), 32'hBEEF);
        chk("mem_0020", 32'(mem.exists(16'h0020) ? mem[16'h0020] : 16'h0000), 32'h2222);
        chk("mem_0051_absent", 32'(mem.exists(16'h0051)), 32'd0);
        chk("mem_0060_absent", 32'(mem.exists(16'h0060)), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
